seq_cska_addsub: RTL and testbench

Multi-cycle, parametrised signed carry-skip adder/subtractor. It processes one BLOCK-bit skip block per clock, LSB block first, and produces a sign-extended WIDTH+1-bit result. It sits in the arithmetic datapath wherever area matters more than latency. It uses valid/ready handshakes on both sides and reports how many blocks took the skip path, for characterisation.

---
 rtl/seq_cska_addsub.sv | 113 +++++++++++
 tb/tb_seq_cska_addsub.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_cska_addsub.sv
// Multi-cycle signed carry-skip add/sub: one BLOCK-bit skip block per clock, LSB first, WIDTH+1-bit result.
// Result valid NBLK cycles after accept; result held in DONE until out_ready, no overlap of operations.
module seq_cska_addsub #(
  parameter int WIDTH = 8,
  parameter int BLOCK = 4,
  localparam int NBLK = WIDTH / BLOCK,
  localparam int CW   = $clog2(NBLK + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic [CW-1:0]    skip_cnt
);

  localparam int BW = (NBLK > 1) ? $clog2(NBLK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [BW-1:0]    blk_q, blk_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic [CW-1:0]    skip_q, skip_d;

  logic [31:0]      base;
  logic [BLOCK-1:0] blk_a, blk_b;
  logic [BLOCK:0]   rip;
  logic             prop;
  logic             cout;

  // Shifts rather than variable part-selects keep the block index width-agnostic.
  assign base  = 32'(blk_q) * 32'(BLOCK);
  assign blk_a = BLOCK'(a_q >> base);
  assign blk_b = BLOCK'(b_q >> base);
  assign rip   = {1'b0, blk_a} + {1'b0, blk_b} + {{BLOCK{1'b0}}, carry_q};
  assign prop  = &(blk_a ^ blk_b);
  assign cout  = prop ? carry_q : rip[BLOCK];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      blk_q   <= '0;
      sum_q   <= '0;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      blk_q   <= blk_d;
      sum_q   <= sum_d;
      skip_q  <= skip_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    blk_d   = blk_q;
    sum_d   = sum_q;
    skip_d  = skip_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub;
          blk_d   = '0;
          skip_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = (sum_q & ~((WIDTH+1)'({BLOCK{1'b1}}) << base))
                | ((WIDTH+1)'(rip[BLOCK-1:0]) << base);
        carry_d = cout;
        if (prop) skip_d = skip_q + CW'(1);
        if (blk_q == BW'(NBLK - 1)) begin
          // Sign extension of the WIDTH-bit sum; the result can never overflow.
          sum_d[WIDTH] = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ cout;
          blk_d        = '0;
          state_d      = DONE;
        end else begin
          blk_d = blk_q + BW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign skip_cnt  = skip_q;

endmodule

// File: tb/tb_seq_cska_addsub.sv
// Directed bench for seq_cska_addsub at WIDTH=8, BLOCK=4 with hand-computed results.
module tb_seq_cska_addsub;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] sum;
  logic [1:0] skip_cnt;

  int checks = 0;
  int errors = 0;

  seq_cska_addsub #(.WIDTH(8), .BLOCK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .skip_cnt  (skip_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, wait for out_valid, hold out_ready low for 'stall' cycles, then drain.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                        input int stall, output logic [8:0] s, output logic [1:0] k,
                        output int lat);
    int guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    a = av; b = bv; sub = sv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    s = sum;
    k = skip_cnt;
    for (int i = 0; i < stall; i++) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (sum !== 9'h000) begin errors++; $display("FAIL reset_sum got %h want 000", sum); end
    checks++;
    if (skip_cnt !== 2'd0) begin errors++; $display("FAIL reset_skip got %0d want 0", skip_cnt); end
  endtask

  task automatic test_vectors();
    logic [7:0] va [8] = '{8'h05, 8'hFF, 8'h7F, 8'h80, 8'h03, 8'h80, 8'h7F, 8'hAA};
    logic [7:0] vb [8] = '{8'h0A, 8'h00, 8'h01, 8'h01, 8'h03, 8'h80, 8'h80, 8'h55};
    logic       vs [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [8:0] es [8] = '{9'h00F, 9'h1FF, 9'h080, 9'h17F, 9'h000, 9'h100, 9'h0FF, 9'h1FF};
    logic [1:0] ek [8] = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd2};
    logic [8:0] s;
    logic [1:0] k;
    int         lat;
    for (int i = 0; i < 8; i++) begin
      run_op(va[i], vb[i], vs[i], 0, s, k, lat);
      checks++;
      if (s !== es[i]) begin
        errors++;
        $display("FAIL vec%0d_sum a=%h b=%h sub=%b got %h want %h", i, va[i], vb[i], vs[i], s, es[i]);
      end
      checks++;
      if (k !== ek[i]) begin
        errors++;
        $display("FAIL vec%0d_skip got %0d want %0d", i, k, ek[i]);
      end
      checks++;
      if (lat !== 2) begin
        errors++;
        $display("FAIL vec%0d_latency got %0d want 2", i, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int guard = 0;
    a = 8'h05; b = 8'h0A; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    // Operand changes during RUN must not disturb the result.
    a = 8'hFF; b = 8'hFF; sub = 1'b1;
    while (!out_valid && guard < 20) begin
      tick();
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || sum !== 9'h00F || skip_cnt !== 2'd1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got vld=%b sum=%h skip=%0d rdy=%b want 1 00f 1 0",
                 i, out_valid, sum, skip_cnt, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    checks++;
    if (skip_cnt !== 2'd1) begin
      errors++;
      $display("FAIL bp_idle_skip_hold got %0d want 1", skip_cnt);
    end
  endtask

  task automatic test_reset_mid_run();
    int spurious = 0;
    a = 8'h03; b = 8'h03; sub = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 9'h000 || skip_cnt !== 2'd0) begin
      errors++;
      $display("FAIL midrun_reset got vld=%b rdy=%b sum=%h skip=%0d want 0 1 000 0",
               out_valid, in_ready, sum, skip_cnt);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) spurious++;
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (spurious !== 0) begin
      errors++;
      $display("FAIL midrun_spurious got %0d out_valid cycles want 0", spurious);
    end
  endtask

  task automatic test_back_to_back();
    int acc [3];
    int n_acc = 0;
    int bad_sum = 0;
    a = 8'hAA; b = 8'h55; sub = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (in_ready && n_acc < 3) begin
        acc[n_acc] = c;
        n_acc++;
      end
      if (out_valid && sum !== 9'h1FF) bad_sum++;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (n_acc !== 3) begin
      errors++;
      $display("FAIL b2b_accepts got %0d want 3", n_acc);
    end else begin
      checks++;
      if (acc[1] - acc[0] !== 4) begin
        errors++;
        $display("FAIL b2b_interval0 got %0d want 4", acc[1] - acc[0]);
      end
      checks++;
      if (acc[2] - acc[1] !== 4) begin
        errors++;
        $display("FAIL b2b_interval1 got %0d want 4", acc[2] - acc[1]);
      end
    end
    checks++;
    if (bad_sum !== 0) begin
      errors++;
      $display("FAIL b2b_sum got %0d wrong results want 0", bad_sum);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0;
    #1;
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
